// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encodings and the quotient reported on a divide-by-zero.
package seq_divider16_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // All-ones quotient flags a zero divisor alongside ov
  localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_Q = 16'hFFFF;

endpackage

// File: rtl/seq_divider16_div_step.sv
// One restoring-division step built from ripple full-adder cells: trial
// subtraction of the divisor from {rem, shift_in}, keep the difference if it fits.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

module div_step
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;

  assign partial  = {rem, shift_in};
  assign sub_b    = ~divisor;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    full_adder u_fa (
      .x   (partial[i]),
      .y   (sub_b[i]),
      .cin (carry[i]),
      .s   (diff[i]),
      .cout(carry[i+1])
    );
  end

  // The divisor's extended top bit is zero, so the final cell reduces to an OR
  assign q_bit    = partial[WIDTH] | carry[WIDTH];
  assign next_rem = q_bit ? diff : partial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned divider: one restoring step per cycle, MSB first,
// with registered busy/done/q/r/ov and back-to-back launch from DONE.
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             ov
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div;
  logic [CW-1:0]    cnt;
  logic             ov_int;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .shift_in(dq[WIDTH-1]),
    .divisor (div),
    .next_rem(step_rem),
    .q_bit   (step_q)
  );

  // Status and result outputs trail the state by one register stage, which
  // keeps busy and done mutually exclusive even on back-to-back launches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      dq     <= '0;
      rem    <= '0;
      div    <= '0;
      cnt    <= '0;
      ov_int <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      r      <= '0;
      ov     <= 1'b0;
    end else begin
      busy <= (state == ST_RUN);
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        q  <= dq;
        r  <= rem;
        ov <= ov_int;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            div <= b;
            cnt <= '0;
            if (b != '0) begin
              dq     <= a;
              rem    <= '0;
              ov_int <= 1'b0;
              state  <= ST_RUN;
            end else begin
              dq     <= WIDTH'(DIV_ZERO_Q);
              rem    <= a;
              ov_int <= 1'b1;
              state  <= ST_DONE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          dq  <= {dq[WIDTH-2:0], step_q};
          rem <= step_rem;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Scoreboard bench for seq_divider16: stimulus pushes expected results and
// latency, a negedge monitor pops and compares on every done pulse.
module tb_seq_divider16;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        ov;
    int          done_cyc;
    int          exp_busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] r;
  logic        ov;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   free_edge = 0;
  int   busy_run = 0;

  seq_divider16 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .ov   (ov)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Waits until the model says the DUT can accept, launches one op and
  // records the result and the edge at which done must appear.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] eq, input logic [15:0] er,
                               input logic eov);
    exp_t e;
    int   n;
    while (cyc < free_edge - 1) begin
      @(posedge clk);
      #1;
    end
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    n          = cyc;
    start      = 1'b0;
    e.q        = eq;
    e.r        = er;
    e.ov       = eov;
    e.done_cyc = n + ((bv != 16'd0) ? 17 : 1);
    e.exp_busy = (bv != 16'd0) ? 16 : 0;
    exp_q.push_back(e);
    free_edge = e.done_cyc;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("q", 32'(q), 32'(e.q));
          checkOutput("r", 32'(r), 32'(e.r));
          checkOutput("ov", 32'(ov), 32'(e.ov));
          checkOutput("done_latency", 32'(cyc), 32'(e.done_cyc));
          checkOutput("busy_with_done", 32'(busy), 32'd0);
          checkOutput("busy_cycles", 32'(busy_run), 32'(e.exp_busy));
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    logic [15:0] av;
    logic [15:0] bv;

    rst   = 1'b1;
    start = 1'b0;
    a     = 16'd0;
    b     = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_q", 32'(q), 32'd0);
    checkOutput("reset_r", 32'(r), 32'd0);
    checkOutput("reset_ov", 32'(ov), 32'd0);
    rst       = 1'b0;
    free_edge = cyc + 1;

    applyStimulus(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    while (cyc < free_edge + 3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold_q", 32'(q), 32'd14);
    checkOutput("hold_r", 32'(r), 32'd2);
    checkOutput("hold_done", 32'(done), 32'd0);

    applyStimulus(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    applyStimulus(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    applyStimulus(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);

    // A start pulse in the middle of a run must be dropped entirely
    applyStimulus(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    a     = 16'd9;
    b     = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    applyStimulus(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);

    // Reset partway through a run abandons it without a done pulse
    applyStimulus(16'd500, 16'd4, 16'd125, 16'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
    checkOutput("midrun_reset_done", 32'(done), 32'd0);
    checkOutput("midrun_reset_q", 32'(q), 32'd0);
    checkOutput("midrun_reset_r", 32'(r), 32'd0);
    checkOutput("midrun_reset_ov", 32'(ov), 32'd0);
    rst       = 1'b0;
    free_edge = cyc + 1;
    applyStimulus(16'd500, 16'd4, 16'd125, 16'd0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      av = 16'($urandom_range(0, 65535));
      bv = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      applyStimulus(av, bv, av / bv, av % bv, 1'b0);
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider16.md
SEQ_DIVIDER16 -- requirements
Module: seq_divider16

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; all behaviour below is stated for 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 a  input  16  unsigned dividend; captured on accepted start.
REQ-006 b  input  16  unsigned divisor; captured on accepted start.
REQ-007 busy  output  1  high while a division is in progress (RUN).
REQ-008 done  output  1  one-cycle pulse when q/r/ov are valid.
REQ-009 q  output  16  unsigned quotient.
REQ-010 r  output  16  unsigned remainder.
REQ-011 ov  output  1  divide-by-zero flag for the last result.

Function
REQ-012 States: IDLE, RUN, DONE; 2-bit encoding.
REQ-013 IDLE: start=1 and b!=0 -> capture a,b, clear remainder accumulator and step counter, go RUN.
REQ-014 IDLE: start=1 and b==0 -> go DONE next cycle with q=16'hFFFF, r=a, ov=1; no RUN cycles.
REQ-015 RUN: exactly 16 cycles, one restoring step per cycle, MSB of dividend first.
REQ-016 Step: partial = {rem[15:0], dividend shift-out bit} (17 bits); if partial >= {1'b0,b} then rem = partial - b and quotient bit = 1, else rem = partial and quotient bit = 0.
REQ-017 Step counter 4 bits, counts 0..15; on count 15 the step completes and state goes DONE.
REQ-018 DONE: lasts one cycle; done=1, q/r/ov updated in this cycle; then IDLE.
REQ-019 DONE with start=1 is accepted as in IDLE (back-to-back operation, no idle gap).
REQ-020 Latency: start accepted at edge N -> done high in cycle following edge N+17 (b!=0) or N+1 (b==0).
REQ-021 start while busy=1 is ignored; a/b changes during RUN do not affect the result.
REQ-022 q, r, ov hold their last values from DONE until the next DONE or reset.
REQ-023 busy=1 exactly in RUN; busy and done never high together.
REQ-024 Result invariant for b!=0: a == q*b + r and r < b; ov=0.
REQ-025 No signed mode; operands and results are unsigned only.

Reset
REQ-026 rst=1 at any edge -> state IDLE, busy=0, done=0, q=0, r=0, ov=0, counter=0, internal registers 0.
REQ-027 rst during RUN abandons the division; no done pulse is produced for it.
REQ-028 rst has priority over start in the same cycle.
REQ-029 First start is accepted in the cycle after rst deasserts.

Structure
REQ-030 Shared package holds WIDTH default, state encodings (IDLE/RUN/DONE) and the divide-by-zero quotient constant 16'hFFFF.
REQ-031 One combinational sub-module div_step: inputs rem(16), shift-in bit, divisor(16); outputs next rem(16) and quotient bit; built on the codebase's ripple adder/subtractor cells.
REQ-032 Top holds FSM, counter, dividend/quotient shift register, remainder register, output registers; one div_step instance.
REQ-033 No multicycle or combinational path from a/b to outputs; all outputs registered.

Verification
REQ-034 a=100, b=7, start 1 cycle -> busy 16 cycles, done 17 cycles after start, q=14, r=2, ov=0.
REQ-035 a=16'hFFFF, b=1 -> q=16'hFFFF, r=0; then a=16'hFFFF, b=16'hFFFF -> q=1, r=0.
REQ-036 a=5, b=0 -> done next cycle after start, busy never high, q=16'hFFFF, r=5, ov=1; next a=3,b=10 -> q=0, r=3, ov=0.
REQ-037 a=1000,b=3 running; at step 5 drive start with a=9,b=9 -> ignored, result q=333, r=1; start held during DONE launches next op with no gap.
REQ-038 rst asserted at step 8 of a=500,b=4 -> next cycle all outputs 0, no done pulse; subsequent a=500,b=4 -> q=125, r=0.
REQ-039 Random unsigned a,b (b!=0), 1000 ops back-to-back -> every result meets REQ-024 against a reference model.
